// File: rtl/src_sel_unit.sv
// Registered operand source selector with per-source ready waiting and valid/ready output.
// Optional wait timeout (d_out forced to 0, err pulse) is built when SRC_SEL_TIMEOUT_EN is defined.
module src_sel_unit #(
    parameter int          WIDTH     = 16,
    parameter int          NUM_SRC   = 8,
    parameter logic [15:0] WAIT_MASK = 16'h000C,
    parameter int          TIMEOUT   = 255,
    localparam int         SEL_W     = $clog2(NUM_SRC)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [SEL_W-1:0]         src_sel,
    input  logic [NUM_SRC*WIDTH-1:0] src_data,
    input  logic [NUM_SRC-1:0]       src_rdy,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         d_out,
    output logic [SEL_W-1:0]         out_src,
    output logic                     err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [SEL_W-1:0]   r_idx;
    logic [SEL_W-1:0]   w_idx;
    logic [SEL_W-1:0]   w_cap_idx;
    logic               w_capture;
    logic               w_to_wait;
    logic               w_release;
    logic [NUM_SRC-1:0] w_mask;
    logic [WIDTH-1:0]   w_chan [NUM_SRC];

    // Out-of-range selects fall back to source 0, as the legacy mux did.
    assign w_idx  = ({{(32-SEL_W){1'b0}}, src_sel} < 32'(NUM_SRC)) ? src_sel : '0;
    assign w_mask = WAIT_MASK[NUM_SRC-1:0];

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_chan
        assign w_chan[g] = src_data[g*WIDTH +: WIDTH];
    end

    assign req_ready = (r_state == IDLE);

`ifdef SRC_SEL_TIMEOUT_EN
    localparam int               CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TMO   = CNT_W'(TIMEOUT);

    logic [CNT_W-1:0] r_cnt;
    logic             r_err;
    logic             w_timeout;

    assign err = r_err;
`else
    assign err = 1'b0;
`endif

    always_comb begin
        w_next    = r_state;
        w_capture = 1'b0;
        w_to_wait = 1'b0;
        w_release = 1'b0;
        w_cap_idx = w_idx;
`ifdef SRC_SEL_TIMEOUT_EN
        w_timeout = 1'b0;
`endif
        case (r_state)
            IDLE: begin
                if (req_valid) begin
                    if (!w_mask[w_idx] || src_rdy[w_idx]) begin
                        w_capture = 1'b1;
                        w_next    = HOLD;
                    end else begin
                        w_to_wait = 1'b1;
                        w_next    = WAIT;
                    end
                end
            end
            WAIT: begin
                w_cap_idx = r_idx;
                if (src_rdy[r_idx]) begin
                    w_capture = 1'b1;
                    w_next    = HOLD;
                end
`ifdef SRC_SEL_TIMEOUT_EN
                else if (r_cnt == TMO) begin
                    w_timeout = 1'b1;
                    w_next    = HOLD;
                end
`endif
            end
            HOLD: begin
                if (out_ready) begin
                    w_release = 1'b1;
                    w_next    = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_idx     <= '0;
            out_valid <= 1'b0;
            d_out     <= '0;
            out_src   <= '0;
        end else begin
            r_state <= w_next;
            if (w_to_wait) begin
                r_idx <= w_idx;
            end
            if (w_capture) begin
                d_out     <= w_chan[w_cap_idx];
                out_src   <= w_cap_idx;
                out_valid <= 1'b1;
            end
`ifdef SRC_SEL_TIMEOUT_EN
            if (w_timeout) begin
                d_out     <= '0;
                out_src   <= r_idx;
                out_valid <= 1'b1;
            end
`endif
            if (w_release) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef SRC_SEL_TIMEOUT_EN
    // Counter restarts on each WAIT entry and saturates at TIMEOUT.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
            r_err <= 1'b0;
        end else begin
            r_err <= w_timeout;
            if (w_to_wait) begin
                r_cnt <= '0;
            end else if (r_state == WAIT && !src_rdy[r_idx] && r_cnt != TMO) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_src_sel_unit.sv
// Directed scoreboard bench for src_sel_unit (default 8-source build plus a 6-source instance
// exercising out-of-range select fallback).
module tb_src_sel_unit;

    typedef struct packed {
        logic [2:0]  src;
        logic [15:0] data;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         req_valid;
    logic         req_ready;
    logic [2:0]   src_sel;
    logic [127:0] src_data;
    logic [7:0]   src_rdy;
    logic         out_valid;
    logic         out_ready;
    logic [15:0]  d_out;
    logic [2:0]   out_src;
    logic         err;

    logic         s6_req_valid;
    logic         s6_req_ready;
    logic [2:0]   s6_src_sel;
    logic [95:0]  s6_src_data;
    logic [5:0]   s6_src_rdy;
    logic         s6_out_valid;
    logic [15:0]  s6_d_out;
    logic [2:0]   s6_out_src;
    logic         s6_err;

    int   vectors    = 0;
    int   miscompares = 0;
    exp_t sbq[$];

    always #5 clk = ~clk;

    src_sel_unit u_dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .src_sel(src_sel), .src_data(src_data), .src_rdy(src_rdy),
        .out_valid(out_valid), .out_ready(out_ready),
        .d_out(d_out), .out_src(out_src), .err(err)
    );

    src_sel_unit #(.NUM_SRC(6)) u_dut6 (
        .clk(clk), .rst(rst),
        .req_valid(s6_req_valid), .req_ready(s6_req_ready),
        .src_sel(s6_src_sel), .src_data(s6_src_data), .src_rdy(s6_src_rdy),
        .out_valid(s6_out_valid), .out_ready(1'b1),
        .d_out(s6_d_out), .out_src(s6_out_src), .err(s6_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setChan(input int i, input logic [15:0] v);
        src_data[i*16 +: 16] = v;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Presents one selection for a single accepting edge; optionally records the expected word.
    task automatic applyStimulus(input logic [2:0] sel, input logic [15:0] expData, input bit push);
        req_valid = 1'b1;
        src_sel   = sel;
        if (push) sbq.push_back('{src: sel, data: expData});
        tick();
        req_valid = 1'b0;
    endtask

    task automatic popCheck(input string tag);
        exp_t e;
        int   n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        checkOutput({tag, "_valid"}, 32'(out_valid), 32'd1);
        if (sbq.size() == 0) begin
            checkOutput({tag, "_sbq_nonempty"}, 32'd0, 32'd1);
        end else begin
            e = sbq.pop_front();
            checkOutput({tag, "_data"}, 32'(d_out), 32'(e.data));
            checkOutput({tag, "_src"}, 32'(out_src), 32'(e.src));
        end
    endtask

    initial begin
        logic [2:0] seq [6];
        bit         errSeen;
        seq = '{3'd0, 3'd7, 3'd6, 3'd2, 3'd5, 3'd1};

        rst          = 1'b1;
        req_valid    = 1'b0;
        src_sel      = '0;
        src_rdy      = '0;
        out_ready    = 1'b0;
        src_data     = '0;
        s6_req_valid = 1'b0;
        s6_src_sel   = '0;
        s6_src_rdy   = '0;
        s6_src_data  = '0;
        for (int i = 0; i < 8; i++) setChan(i, 16'(16'h1000 + i));
        for (int i = 0; i < 6; i++) s6_src_data[i*16 +: 16] = 16'(16'hA000 + i);
        tick();
        tick();
        rst = 1'b0;

        checkOutput("rst_req_ready", 32'(req_ready), 32'd1);
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_d_out", 32'(d_out), 32'd0);
        checkOutput("rst_out_src", 32'(out_src), 32'd0);
        checkOutput("rst_err", 32'(err), 32'd0);

        // Immediate source with consumer stall
        setChan(1, 16'h1234);
        applyStimulus(3'd1, 16'h1234, 1'b1);
        checkOutput("imm_latency1", 32'(out_valid), 32'd1);
        popCheck("imm");
        setChan(1, 16'hFFFF);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("hold_stable_data", 32'(d_out), 32'h1234);
            checkOutput("hold_stable_valid", 32'(out_valid), 32'd1);
            checkOutput("hold_req_ready", 32'(req_ready), 32'd0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checkOutput("release_valid", 32'(out_valid), 32'd0);
        checkOutput("release_req_ready", 32'(req_ready), 32'd1);

        // Wait source: other channels' ready flags must be ignored
        setChan(2, 16'hBEEF);
        src_rdy = 8'hFB;
        applyStimulus(3'd2, 16'hBEEF, 1'b1);
        for (int i = 0; i < 4; i++) begin
            checkOutput("wait_req_ready", 32'(req_ready), 32'd0);
            checkOutput("wait_out_valid", 32'(out_valid), 32'd0);
            tick();
        end
        src_rdy = 8'h04;
        tick();
        checkOutput("wait_cap_latency", 32'(out_valid), 32'd1);
        popCheck("wait");
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        src_rdy   = 8'h00;

        // Wait source already ready at accept captures in one cycle
        setChan(3, 16'h3C3C);
        src_rdy = 8'h08;
        applyStimulus(3'd3, 16'h3C3C, 1'b1);
        checkOutput("rdy_now_latency", 32'(out_valid), 32'd1);
        popCheck("rdy_now");
        out_ready = 1'b1;
        tick();
        src_rdy = 8'h00;

        // Back-to-back with out_ready tied high; request stays asserted through HOLD
        setChan(7, 16'h0007);
        setChan(6, 16'h0666);
        src_rdy = 8'hFF;
        for (int i = 0; i < 6; i++) begin
            checkOutput("b2b_req_ready_hi", 32'(req_ready), 32'd1);
            req_valid = 1'b1;
            src_sel   = seq[i];
            sbq.push_back('{src: seq[i], data: src_data[seq[i]*16 +: 16]});
            tick();
            checkOutput("b2b_req_ready_lo", 32'(req_ready), 32'd0);
            popCheck("b2b");
            tick();
        end
        req_valid = 1'b0;
        out_ready = 1'b0;
        src_rdy   = 8'h00;

        // Reset during WAIT; a late ready must not produce output
        applyStimulus(3'd2, 16'h0, 1'b0);
        tick();
        rst = 1'b1;
        tick();
        rst     = 1'b0;
        src_rdy = 8'hFF;
        checkOutput("rstw_req_ready", 32'(req_ready), 32'd1);
        tick();
        tick();
        checkOutput("rstw_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rstw_d_out", 32'(d_out), 32'd0);
        src_rdy = 8'h00;

        // Reset during HOLD
        applyStimulus(3'd1, 16'h0, 1'b0);
        checkOutput("rsth_pre_valid", 32'(out_valid), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("rsth_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rsth_d_out", 32'(d_out), 32'd0);
        checkOutput("rsth_out_src", 32'(out_src), 32'd0);
        checkOutput("rsth_req_ready", 32'(req_ready), 32'd1);

        // Long wait: no timeout in the default build
        setChan(2, 16'h5A5A);
        applyStimulus(3'd2, 16'h5A5A, 1'b1);
        errSeen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (err) errSeen = 1'b1;
            tick();
        end
        checkOutput("long_wait_valid", 32'(out_valid), 32'd0);
        checkOutput("long_wait_req_ready", 32'(req_ready), 32'd0);
        checkOutput("long_wait_err", 32'(errSeen), 32'd0);
        src_rdy = 8'h04;
        popCheck("long_wait");
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        src_rdy   = 8'h00;
        checkOutput("sbq_empty", 32'(sbq.size()), 32'd0);

        // Six-source instance: selects 6 and 7 fall back to source 0
        s6_req_valid = 1'b1;
        s6_src_sel   = 3'd7;
        tick();
        s6_req_valid = 1'b0;
        checkOutput("s6_sel7_valid", 32'(s6_out_valid), 32'd1);
        checkOutput("s6_sel7_data", 32'(s6_d_out), 32'hA000);
        tick();
        s6_req_valid = 1'b1;
        s6_src_sel   = 3'd5;
        tick();
        s6_req_valid = 1'b0;
        checkOutput("s6_sel5_data", 32'(s6_d_out), 32'hA005);
        checkOutput("s6_sel5_src", 32'(s6_out_src), 32'd5);
        tick();
        s6_req_valid = 1'b1;
        s6_src_sel   = 3'd6;
        tick();
        s6_req_valid = 1'b0;
        checkOutput("s6_sel6_data", 32'(s6_d_out), 32'hA000);
        checkOutput("s6_err", 32'(s6_err), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/src_sel_unit.md
Name: src_sel_unit

Overview:
- Parametrised, registered successor to the CPU datapath operand source mux.
- Selects one of NUM_SRC source words of WIDTH bits and registers it.
- Slow sources (memory, I/O) are waited on via per-source ready flags; consumer side uses a valid/ready handshake.
- Sits between the decode stage (issues src_sel) and the ALU/writeback operand register.

Parameters:
- WIDTH, 16, data width of every source and of d_out.
- NUM_SRC, 8, number of source channels; legal 2..16.
- SEL_W, $clog2(NUM_SRC), select width; derived, not overridden.
- WAIT_MASK, 16'h000C, bit i set means source i needs src_rdy[i] before capture. Default marks source 2 (mem) and source 3 (io).
- TIMEOUT, 255, wait cycles before abort; used only with the optional feature.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  decode presents a selection.
- req_ready  out  1  unit can accept a selection; high only in IDLE.
- src_sel  in  SEL_W  source index; sampled when req_valid && req_ready.
- src_data  in  NUM_SRC*WIDTH  packed sources; channel i at [i*WIDTH +: WIDTH].
- src_rdy  in  NUM_SRC  per-source data-ready; ignored for sources not in WAIT_MASK.
- out_valid  out  1  d_out holds a captured word.
- out_ready  in  1  consumer accepts d_out.
- d_out  out  WIDTH  registered selected data.
- out_src  out  SEL_W  index of the source that produced d_out.
- err  out  1  one-cycle pulse on wait timeout.

Behaviour:
- Reset (rst high at a clock edge):
  - state=IDLE; out_valid=0; d_out=0; out_src=0; err=0; wait counter=0.
  - Reset overrides everything, including an in-progress WAIT or HOLD; no partial result survives.
- Index resolution: an out-of-range src_sel (>= NUM_SRC) resolves to source 0, matching the legacy default.
- States: IDLE, WAIT, HOLD.
- IDLE:
  - req_ready=1.
  - On accept with a non-wait source (WAIT_MASK bit clear): d_out <= that channel's data, out_src <= index, out_valid <= 1, go to HOLD. Latency 1 cycle.
  - On accept with a wait source and src_rdy[idx]=1 in the same cycle: capture immediately, as for a non-wait source.
  - On accept with a wait source and src_rdy[idx]=0: latch the index, clear the counter, go to WAIT.
- WAIT:
  - req_ready=0.
  - Each cycle, check src_rdy[latched idx]. When it is 1: capture that cycle's src_data, out_valid <= 1, go to HOLD.
  - Otherwise the counter increments, saturating at TIMEOUT.
- HOLD:
  - out_valid=1; d_out and out_src stay stable while out_ready=0.
  - When out_ready=1: out_valid <= 0, go to IDLE.
  - A new request is not accepted in the same cycle; back-to-back throughput is one word per 2 cycles.
- Source data is only sampled at capture; source changes during HOLD do not affect d_out.
- src_rdy of non-selected channels is ignored at all times.

Optional Feature:
- Macro: SRC_SEL_TIMEOUT_EN.
- Defined:
  - In WAIT, when the counter reaches TIMEOUT with src_rdy still 0, go to HOLD with d_out <= 0, out_src <= latched index, out_valid <= 1.
  - err pulses high for exactly that cycle.
  - The counter clears on every WAIT entry.
- Undefined: WAIT lasts indefinitely; no counter logic is built; err is tied to 0.

Test Plan:
- Reset, then req src_sel=1 with imm=16'h1234 -> next cycle out_valid=1, d_out=16'h1234, out_src=1. Hold out_ready=0 for 3 cycles -> d_out stable; then out_ready=1 -> IDLE, req_ready=1.
- src_sel=2 with src_rdy[2]=0 for 4 cycles, then 1 with mem=16'hBEEF -> req_ready=0 throughout WAIT; out_valid one cycle after rdy, d_out=16'hBEEF.
- src_sel=3, NUM_SRC=8, src_sel=7 (valid, data 16'h0007) and src_sel=6 -> correct channel data; with NUM_SRC=6, src_sel=7 -> d_out = source 0 data.
- rst asserted during WAIT and again during HOLD -> next cycle state=IDLE, out_valid=0, d_out=0; the late src_rdy is ignored.
- SRC_SEL_TIMEOUT_EN with TIMEOUT=4, src_sel=2, src_rdy never set -> err single-cycle pulse, out_valid=1, d_out=0, out_src=2. Without the macro -> still waiting after 100 cycles, err=0.
- Back-to-back requests with out_ready=1 tied high -> req_ready toggles 1/0; one word per 2 cycles; out_src sequence matches the requests.
